branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 134 +++++++++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating counters.
// Zero-latency fetch lookup, Execute-stage mispredict detection and update, resolve/mispredict counters.
module branch_predictor #(
  parameter int WIDTH    = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PCF,
  output logic             PredTakenF,
  output logic [WIDTH-1:0] PredTargetF,
  input  logic             ResolveE,
  input  logic             IsJumpE,
  input  logic             TakenE,
  input  logic [WIDTH-1:0] PCE,
  input  logic [WIDTH-1:0] TargetE,
  input  logic [WIDTH-1:0] PCPlus4E,
  input  logic             PredTakenE,
  input  logic [WIDTH-1:0] PredTargetE,
  input  logic             InvalidateAll,
  output logic             FlushBranch,
  output logic [WIDTH-1:0] PCRedirect,
  output logic [31:0]      BranchCount,
  output logic [31:0]      MispredCount
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = WIDTH - IDX - 2;

  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_W-1:0]    tag_reg    [ENTRIES];
  logic [WIDTH-1:0]    target_reg [ENTRIES];
  logic [CNT_BITS-1:0] cnt_reg    [ENTRIES];

  logic [31:0] branch_count_reg;
  logic [31:0] mispred_count_reg;

  // Word-aligned PCs: the two low address bits never take part in index or tag.
  logic unused_bits;
  assign unused_bits = &{1'b0, PCF[1:0], PCE[1:0]};

  // Fetch-side lookup
  logic [IDX-1:0]   idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;

  assign idx_f = PCF[IDX+1:2];
  assign tag_f = PCF[WIDTH-1:IDX+2];
  assign hit_f = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);

  assign PredTakenF  = hit_f && cnt_reg[idx_f][CNT_BITS-1];
  assign PredTargetF = PredTakenF ? target_reg[idx_f] : '0;

  // Execute-side resolution
  assign FlushBranch = ResolveE && ((TakenE != PredTakenE) || (TakenE && (PredTargetE != TargetE)));
  assign PCRedirect  = TakenE ? TargetE : PCPlus4E;

  logic [IDX-1:0]      idx_e;
  logic [TAG_W-1:0]    tag_e;
  logic                hit_e;
  logic [CNT_BITS-1:0] cnt_cur;
  logic [CNT_BITS-1:0] cnt_next;
  logic [WIDTH-1:0]    target_next;
  logic                wr_en;

  assign idx_e = PCE[IDX+1:2];
  assign tag_e = PCE[WIDTH-1:IDX+2];

  always_comb begin
    cnt_cur     = cnt_reg[idx_e];
    hit_e       = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);
    wr_en       = 1'b0;
    cnt_next    = cnt_cur;
    target_next = target_reg[idx_e];
    // A concurrent invalidate suppresses the whole update, including allocation.
    if (ResolveE && !InvalidateAll) begin
      if (IsJumpE && TakenE) begin
        wr_en       = 1'b1;
        cnt_next    = CNT_MAX;
        target_next = TargetE;
      end else if (TakenE) begin
        wr_en       = 1'b1;
        target_next = TargetE;
        if (!hit_e)
          cnt_next = CNT_WT;
        else if (cnt_cur != CNT_MAX)
          cnt_next = cnt_cur + CNT_BITS'(1);
      end else if (hit_e) begin
        wr_en = 1'b1;
        if (cnt_cur != '0)
          cnt_next = cnt_cur - CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        cnt_reg[i]    <= CNT_WNT;
      end
    end else if (InvalidateAll) begin
      valid_reg <= '0;
    end else if (wr_en) begin
      valid_reg[idx_e]  <= 1'b1;
      tag_reg[idx_e]    <= tag_e;
      target_reg[idx_e] <= target_next;
      cnt_reg[idx_e]    <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count_reg  <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (ResolveE && (branch_count_reg != 32'hFFFF_FFFF))
        branch_count_reg <= branch_count_reg + 32'd1;
      if (FlushBranch && (mispred_count_reg != 32'hFFFF_FFFF))
        mispred_count_reg <= mispred_count_reg + 32'd1;
    end
  end

  assign BranchCount  = branch_count_reg;
  assign MispredCount = mispred_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: vector table for learn/alias/jump/invalidate behaviour,
// plus hand sequences for reset, asynchronous reset mid-update and counter saturation.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        ResolveE;
  logic        IsJumpE;
  logic        TakenE;
  logic [31:0] PCE;
  logic [31:0] TargetE;
  logic [31:0] PCPlus4E;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        InvalidateAll;
  logic        FlushBranch;
  logic [31:0] PCRedirect;
  logic [31:0] BranchCount;
  logic [31:0] MispredCount;

  int tests  = 0;
  int failed = 0;

  branch_predictor #(.WIDTH(32), .ENTRIES(16), .CNT_BITS(2)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .ResolveE(ResolveE), .IsJumpE(IsJumpE), .TakenE(TakenE), .PCE(PCE), .TargetE(TargetE),
    .PCPlus4E(PCPlus4E), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .InvalidateAll(InvalidateAll), .FlushBranch(FlushBranch), .PCRedirect(PCRedirect),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        res;
    logic        jmp;
    logic        tkn;
    logic [31:0] pce;
    logic [31:0] tgt;
    logic        ptkn;
    logic [31:0] ptgt;
    logic        inv;
    logic [31:0] pcf;
    logic        flush;
    logic [31:0] redir;
    logic        pre;
    logic        post;
    logic [31:0] post_tgt;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    ResolveE = 0; IsJumpE = 0; TakenE = 0; PCE = 0; TargetE = 0;
    PCPlus4E = 0; PredTakenE = 0; PredTargetE = 0; InvalidateAll = 0;
  endtask

  // Correctly predicted resolve: no flush, only the table and BranchCount move.
  task automatic do_resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    @(negedge clk);
    ResolveE = 1; PCE = pc; TakenE = tk; TargetE = tg; PCPlus4E = pc + 32'd4;
    PredTakenE = tk; PredTargetE = tg;
    @(posedge clk);
    #1 set_idle();
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic exp);
    PCF = pc;
    #1 check(name, {31'd0, PredTakenF}, {31'd0, exp});
  endtask

  initial begin
    //          res jmp tkn pce        tgt        ptkn ptgt      inv pcf        flush redir     pre post post_tgt
    vecs[0]  = '{1, 0, 1, 32'h40,  32'h80,  0, 32'h0,   0, 32'h40,  1, 32'h80,  0, 1, 32'h80};
    vecs[1]  = '{1, 0, 0, 32'h40,  32'h0,   1, 32'h80,  0, 32'h40,  1, 32'h44,  1, 0, 32'h0};
    vecs[2]  = '{1, 0, 1, 32'h40,  32'h80,  0, 32'h0,   0, 32'h40,  1, 32'h80,  0, 1, 32'h80};
    vecs[3]  = '{1, 0, 1, 32'h40,  32'h80,  1, 32'h80,  0, 32'h40,  0, 32'h0,   1, 1, 32'h80};
    vecs[4]  = '{1, 0, 0, 32'h40,  32'h0,   1, 32'h80,  0, 32'h40,  1, 32'h44,  1, 1, 32'h80};
    vecs[5]  = '{0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h80,  0, 32'h0,   0, 0, 32'h0};
    vecs[6]  = '{1, 0, 1, 32'h80,  32'h200, 0, 32'h0,   0, 32'h40,  1, 32'h200, 1, 0, 32'h0};
    vecs[7]  = '{0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h80,  0, 32'h0,   1, 1, 32'h200};
    vecs[8]  = '{1, 0, 1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h80,  1, 32'h100, 1, 1, 32'h100};
    vecs[9]  = '{1, 1, 1, 32'h104, 32'h300, 1, 32'h300, 0, 32'h104, 0, 32'h0,   0, 1, 32'h300};
    vecs[10] = '{1, 0, 0, 32'h104, 32'h0,   1, 32'h300, 0, 32'h104, 1, 32'h108, 1, 1, 32'h300};
    vecs[11] = '{1, 0, 0, 32'h208, 32'h0,   0, 32'h0,   0, 32'h208, 0, 32'h0,   0, 0, 32'h0};
    vecs[12] = '{1, 0, 1, 32'h30C, 32'h400, 0, 32'h0,   1, 32'h80,  1, 32'h400, 1, 0, 32'h0};
    vecs[13] = '{0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h30C, 0, 32'h0,   0, 0, 32'h0};
    vecs[14] = '{0, 0, 0, 32'h0,   32'h0,   0, 32'h0,   0, 32'h104, 0, 32'h0,   0, 0, 32'h0};

    // Reset state; flush logic stays purely combinational while in reset.
    set_idle();
    rst = 0;
    PCF = 32'h40;
    repeat (2) @(posedge clk);
    #1;
    check("reset_pred_taken", {31'd0, PredTakenF}, 32'd0);
    check("reset_pred_target", PredTargetF, 32'd0);
    check("reset_branch_count", BranchCount, 32'd0);
    check("reset_mispred_count", MispredCount, 32'd0);
    ResolveE = 1; TakenE = 1; TargetE = 32'h80; PredTakenE = 0;
    #1 check("reset_flush_comb", {31'd0, FlushBranch}, 32'd1);
    set_idle();
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ResolveE = vecs[i].res; IsJumpE = vecs[i].jmp; TakenE = vecs[i].tkn;
      PCE = vecs[i].pce; TargetE = vecs[i].tgt; PCPlus4E = vecs[i].pce + 32'd4;
      PredTakenE = vecs[i].ptkn; PredTargetE = vecs[i].ptgt;
      InvalidateAll = vecs[i].inv; PCF = vecs[i].pcf;
      #1;
      check($sformatf("v%0d_flush", i), {31'd0, FlushBranch}, {31'd0, vecs[i].flush});
      if (vecs[i].flush)
        check($sformatf("v%0d_redirect", i), PCRedirect, vecs[i].redir);
      check($sformatf("v%0d_pre_taken", i), {31'd0, PredTakenF}, {31'd0, vecs[i].pre});
      @(posedge clk);
      #1 set_idle();
      #1;
      check($sformatf("v%0d_post_taken", i), {31'd0, PredTakenF}, {31'd0, vecs[i].post});
      check($sformatf("v%0d_post_target", i), PredTargetF, vecs[i].post_tgt);
      $display("[TB] vec %0d pcf=0x%0h flush=%b redirect=0x%0h pred=%b target=0x%0h",
               i, vecs[i].pcf, vecs[i].flush, vecs[i].redir, PredTakenF, PredTargetF);
    end
    check("table_branch_count", BranchCount, 32'd11);
    check("table_mispred_count", MispredCount, 32'd8);

    // Train a fresh entry, then hit it with asynchronous reset in the middle of an update.
    for (int k = 0; k < 4; k++) do_resolve(32'h514, 1'b1, 32'h700);
    lookup("pre_rst_pred", 32'h514, 1'b1);
    check("pre_rst_branch_count", BranchCount, 32'd15);
    check("pre_rst_mispred_count", MispredCount, 32'd8);
    @(negedge clk);
    ResolveE = 1; TakenE = 1; PCE = 32'h600; TargetE = 32'h800; PCPlus4E = 32'h604;
    PredTakenE = 0; PCF = 32'h514;
    #2 rst = 0;
    #1;
    check("midrst_pred_taken", {31'd0, PredTakenF}, 32'd0);
    check("midrst_pred_target", PredTargetF, 32'd0);
    check("midrst_branch_count", BranchCount, 32'd0);
    check("midrst_mispred_count", MispredCount, 32'd0);
    check("midrst_flush_comb", {31'd0, FlushBranch}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    rst = 1;
    lookup("postrst_no_alloc", 32'h600, 1'b0);
    lookup("postrst_entry_gone", 32'h514, 1'b0);
    check("postrst_branch_count", BranchCount, 32'd0);
    $display("[TB] async reset mid-update done");

    // Two-bit counter saturation in both directions.
    for (int k = 0; k < 4; k++) do_resolve(32'h514, 1'b1, 32'h700);
    lookup("sat_up_pred", 32'h514, 1'b1);
    do_resolve(32'h514, 1'b0, 32'h0);
    lookup("sat_up_one_nt", 32'h514, 1'b1);
    for (int k = 0; k < 5; k++) do_resolve(32'h514, 1'b0, 32'h0);
    lookup("sat_down_pred", 32'h514, 1'b0);
    do_resolve(32'h514, 1'b1, 32'h700);
    lookup("sat_down_one_t", 32'h514, 1'b0);
    do_resolve(32'h514, 1'b1, 32'h700);
    lookup("sat_down_two_t", 32'h514, 1'b1);
    check("sat_branch_count", BranchCount, 32'd12);
    check("sat_mispred_count", MispredCount, 32'd0);
    $display("[TB] counter saturation sequence done");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
